// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if
// Request/response bundle between operand fetch, the multi-cycle ALU and
// writeback.
//   request : in_valid, in_ready, operation[3:0], a[WIDTH], b[WIDTH]
//   response: out_valid, out_ready, result[WIDTH], carryFlag, negativeFlag,
//             overFlowFlag, zeroFlag
// The master modport is the environment (producer and consumer).
// The slave modport is the ALU.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryFlag;
    logic             negativeFlag;
    logic             overFlowFlag;
    logic             zeroFlag;

    modport master (
        output in_valid, operation, a, b, out_ready,
        input  in_ready, out_valid, result, carryFlag, negativeFlag,
               overFlowFlag, zeroFlag
    );

    modport slave (
        input  in_valid, operation, a, b, out_ready,
        output in_ready, out_valid, result, carryFlag, negativeFlag,
               overFlowFlag, zeroFlag
    );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle
// Handshaked, registered ALU. Logic, arithmetic, shift and compare ops
// finish in one cycle. CLO/CLZ use an iterative leading-bit counter.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      alu_multicycle_if.slave: valid/ready request with operation/a/b,
//            valid/ready response with result and four flags
//
// state | meaning
// IDLE  | waiting for a request
// COUNT | CLO/CLZ iteration, one leading bit per cycle
// HOLD  | result and flags presented, out_valid = 1
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int CNT_W   = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            reset_n,
    alu_multicycle_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t           state;
    logic             outValid;
    logic [WIDTH-1:0] resultReg;
    logic             carryReg;
    logic             negReg;
    logic             ovfReg;
    logic             zeroReg;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] count;

    logic             inReady;
    logic             accept;
    logic             isCountOp;
    logic [WIDTH-1:0] opRes;
    logic             opCarry;
    logic             opOvf;
    logic [WIDTH:0]   sumWide;
    logic [WIDTH:0]   diffWide;
    logic [WIDTH:0]   shlWide;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] countRes;

    assign inReady   = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    assign accept    = bus.in_valid && inReady;
    assign isCountOp = (bus.operation == 4'hE) || (bus.operation == 4'hF);
    assign countRes  = {{(WIDTH-CNT_W){1'b0}}, count};

    always_comb begin
        opRes   = '0;
        opCarry = 1'b0;
        opOvf   = 1'b0;
        shamt   = bus.b[SHAMT_W-1:0];
        sumWide  = {1'b0, bus.a} + {1'b0, bus.b};
        // MSB of the widened difference is the unsigned borrow (a < b).
        diffWide = {1'b0, bus.a} - {1'b0, bus.b};
        // Bit WIDTH of the widened left shift is the last bit shifted out,
        // and is naturally 0 for a zero shift amount.
        shlWide  = {1'b0, bus.a} << shamt;
        case (bus.operation)
            4'h0: opRes = bus.a & bus.b;
            4'h1: opRes = bus.a | bus.b;
            4'h2: opRes = bus.a ^ bus.b;
            4'h3: opRes = ~(bus.a | bus.b);
            4'h4: begin
                opRes   = sumWide[WIDTH-1:0];
                opCarry = sumWide[WIDTH];
            end
            4'h5: begin
                opRes   = diffWide[WIDTH-1:0];
                opCarry = diffWide[WIDTH];
            end
            4'h6: begin
                opRes = sumWide[WIDTH-1:0];
                opOvf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (sumWide[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'h7: begin
                opRes = diffWide[WIDTH-1:0];
                opOvf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (diffWide[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'h8: begin
                opRes   = {bus.a[WIDTH-2:0], 1'b0};
                opCarry = bus.a[WIDTH-1];
            end
            4'h9: begin
                opRes   = shlWide[WIDTH-1:0];
                opCarry = shlWide[WIDTH];
            end
            4'hA: opRes = {1'b0, bus.a[WIDTH-1:1]};
            4'hB: opRes = bus.a >> shamt;
            4'hC: opRes = WIDTH'($signed(bus.a) < $signed(bus.b));
            4'hD: opRes = WIDTH'(bus.a < bus.b);
            default: opRes = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            outValid  <= 1'b0;
            resultReg <= '0;
            carryReg  <= 1'b0;
            negReg    <= 1'b0;
            ovfReg    <= 1'b0;
            zeroReg   <= 1'b0;
            shreg     <= '0;
            count     <= '0;
        end else if (accept) begin
            if (isCountOp) begin
                // CLO counts leading ones by counting leading zeros of ~a.
                shreg    <= (bus.operation == 4'hE) ? ~bus.a : bus.a;
                count    <= '0;
                state    <= COUNT;
                outValid <= 1'b0;
            end else begin
                resultReg <= opRes;
                carryReg  <= opCarry;
                ovfReg    <= opOvf;
                negReg    <= opRes[WIDTH-1];
                zeroReg   <= (opRes == '0);
                state     <= HOLD;
                outValid  <= 1'b1;
            end
        end else begin
            case (state)
                COUNT: begin
                    if (shreg[WIDTH-1] || (count == CNT_MAX)) begin
                        resultReg <= countRes;
                        carryReg  <= 1'b0;
                        ovfReg    <= 1'b0;
                        negReg    <= countRes[WIDTH-1];
                        zeroReg   <= (count == '0);
                        state     <= HOLD;
                        outValid  <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                        shreg <= shreg << 1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.out_valid    = outValid;
    assign bus.result       = resultReg;
    assign bus.carryFlag    = carryReg;
    assign bus.negativeFlag = negReg;
    assign bus.overFlowFlag = ovfReg;
    assign bus.zeroFlag     = zeroReg;
endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    alu_multicycle_if #(.WIDTH(32)) aluBus ();

    alu_multicycle #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (aluBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from IDLE and wait for out_valid. lat counts cycles
    // from the accepting edge; hitting the bound returns lat = 60.
    task automatic doOp(input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, output int lat,
                        output bit readySeen);
        aluBus.operation = op;
        aluBus.a         = av;
        aluBus.b         = bv;
        aluBus.in_valid  = 1'b1;
        @(posedge clk); #1;
        aluBus.in_valid  = 1'b0;
        aluBus.operation = 4'h0;
        aluBus.a         = 32'h5A5A_5A5A;
        aluBus.b         = 32'hFFFF_FFFF;
        lat       = 1;
        readySeen = 1'b0;
        while (!aluBus.out_valid && lat < 60) begin
            if (aluBus.in_ready) readySeen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        aluBus.out_ready = 1'b1;
        @(posedge clk); #1;
        aluBus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        aluBus.in_valid  = 1'b0;
        aluBus.out_ready = 1'b0;
        aluBus.operation = 4'h0;
        aluBus.a         = '0;
        aluBus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (aluBus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", aluBus.out_valid);
        end
        checks++;
        if (aluBus.result !== 32'h0) begin
            errors++; $display("FAIL reset_result got %h want 0", aluBus.result);
        end
        checks++;
        if ({aluBus.carryFlag, aluBus.negativeFlag, aluBus.overFlowFlag, aluBus.zeroFlag} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b%b want 0000", aluBus.carryFlag,
                     aluBus.negativeFlag, aluBus.overFlowFlag, aluBus.zeroFlag);
        end
        checks++;
        if (aluBus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", aluBus.in_ready);
        end
    endtask

    task automatic test_single_cycle();
        logic [3:0]  vOp  [17] = '{4'h4, 4'h4, 4'h6, 4'h6, 4'h7, 4'h5, 4'h5, 4'hC, 4'hD,
                                   4'h9, 4'h9, 4'h8, 4'hA, 4'hB, 4'h0, 4'h1, 4'h3};
        logic [31:0] vA   [17] = '{32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                   32'h8000_0000, 32'h3, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h8000_0001, 32'h8000_0001, 32'hC000_0001, 32'h8000_0003,
                                   32'hF000_0000, 32'hF0, 32'hF0, 32'h0};
        logic [31:0] vB   [17] = '{32'h1, 32'h1, 32'h1, 32'h8000_0000, 32'h1, 32'h5, 32'h3,
                                   32'h1, 32'h1, 32'h21, 32'h20, 32'h7, 32'h7, 32'h24,
                                   32'h3C, 32'h0F, 32'h0};
        logic [31:0] vRes [17] = '{32'h0, 32'h2, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF,
                                   32'hFFFF_FFFE, 32'h2, 32'h1, 32'h0, 32'h2, 32'h8000_0001,
                                   32'h8000_0002, 32'h4000_0001, 32'h0F00_0000, 32'h30,
                                   32'hFF, 32'hFFFF_FFFF};
        logic        vC   [17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        vV   [17] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat;
        bit readySeen;
        logic [31:0] expRes;
        for (int i = 0; i < 17; i++) begin
            expRes = vRes[i];
            doOp(vOp[i], vA[i], vB[i], lat, readySeen);
            checks++;
            if (lat !== 1) begin
                errors++; $display("FAIL single_latency vec %0d got %0d want 1", i, lat);
            end
            checks++;
            if (aluBus.result !== expRes) begin
                errors++; $display("FAIL single_result vec %0d got %h want %h", i, aluBus.result, expRes);
            end
            checks++;
            if (aluBus.carryFlag !== vC[i] || aluBus.overFlowFlag !== vV[i]) begin
                errors++;
                $display("FAIL single_cv vec %0d got c%b v%b want c%b v%b", i,
                         aluBus.carryFlag, aluBus.overFlowFlag, vC[i], vV[i]);
            end
            checks++;
            if (aluBus.negativeFlag !== expRes[31] || aluBus.zeroFlag !== (expRes == 32'h0)) begin
                errors++;
                $display("FAIL single_nz vec %0d got n%b z%b want n%b z%b", i,
                         aluBus.negativeFlag, aluBus.zeroFlag, expRes[31], (expRes == 32'h0));
            end
            releaseResult();
            checks++;
            if (aluBus.out_valid !== 1'b0) begin
                errors++; $display("FAIL single_drop vec %0d out_valid got %b want 0", i, aluBus.out_valid);
            end
        end
    endtask

    task automatic test_count();
        logic [3:0]  vOp [6] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hE};
        logic [31:0] vA  [6] = '{32'h0001_0000, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                 32'h0000_0001, 32'hFFF0_0000};
        int          vL  [6] = '{15, 32, 32, 0, 31, 12};
        int lat;
        bit readySeen;
        for (int i = 0; i < 6; i++) begin
            doOp(vOp[i], vA[i], 32'h0, lat, readySeen);
            checks++;
            if (lat !== vL[i] + 2) begin
                errors++; $display("FAIL count_latency vec %0d got %0d want %0d", i, lat, vL[i] + 2);
            end
            checks++;
            if (aluBus.result !== 32'(vL[i])) begin
                errors++; $display("FAIL count_result vec %0d got %0d want %0d", i, aluBus.result, vL[i]);
            end
            checks++;
            if (readySeen !== 1'b0) begin
                errors++; $display("FAIL count_in_ready vec %0d got 1 during COUNT want 0", i);
            end
            checks++;
            if ({aluBus.carryFlag, aluBus.negativeFlag, aluBus.overFlowFlag} !== 3'b000 ||
                aluBus.zeroFlag !== (vL[i] == 0)) begin
                errors++;
                $display("FAIL count_flags vec %0d got c%b n%b v%b z%b want c0 n0 v0 z%b", i,
                         aluBus.carryFlag, aluBus.negativeFlag, aluBus.overFlowFlag,
                         aluBus.zeroFlag, (vL[i] == 0));
            end
            releaseResult();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit readySeen;
        doOp(4'h7, 32'h8000_0000, 32'h1, lat, readySeen);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (aluBus.out_valid !== 1'b1 || aluBus.result !== 32'h7FFF_FFFF ||
                aluBus.overFlowFlag !== 1'b1 || aluBus.negativeFlag !== 1'b0 ||
                aluBus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got v%b r%h o%b n%b rdy%b want v1 r7fffffff o1 n0 rdy0",
                         i, aluBus.out_valid, aluBus.result, aluBus.overFlowFlag,
                         aluBus.negativeFlag, aluBus.in_ready);
            end
        end
        aluBus.out_ready = 1'b1;
        aluBus.in_valid  = 1'b1;
        aluBus.operation = 4'h0;
        aluBus.a         = 32'hF0;
        aluBus.b         = 32'h3C;
        #1;
        checks++;
        if (aluBus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_in_ready got %b want 1", aluBus.in_ready);
        end
        @(posedge clk); #1;
        aluBus.in_valid = 1'b0;
        checks++;
        if (aluBus.out_valid !== 1'b1 || aluBus.result !== 32'h30 || aluBus.overFlowFlag !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result got v%b r%h o%b want v1 r00000030 o0",
                     aluBus.out_valid, aluBus.result, aluBus.overFlowFlag);
        end
        @(posedge clk); #1;
        aluBus.out_ready = 1'b0;
        checks++;
        if (aluBus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drop got %b want 0", aluBus.out_valid);
        end
    endtask

    task automatic test_reset_in_count();
        bit sawValid;
        aluBus.operation = 4'hF;
        aluBus.a         = 32'h0;
        aluBus.in_valid  = 1'b1;
        @(posedge clk); #1;
        aluBus.in_valid  = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if (aluBus.out_valid !== 1'b0 || aluBus.result !== 32'h0 || aluBus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midcount_reset got v%b r%h rdy%b want v0 r00000000 rdy1",
                     aluBus.out_valid, aluBus.result, aluBus.in_ready);
        end
        aluBus.out_ready = 1'b1;
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (aluBus.out_valid) sawValid = 1'b1;
        end
        aluBus.out_ready = 1'b0;
        checks++;
        if (sawValid !== 1'b0) begin
            errors++; $display("FAIL midcount_stale got out_valid 1 after reset want 0");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_cycle();
        test_count();
        test_back_to_back();
        test_reset_in_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
